vmove_seq: RTL and testbench
============================

Name: vmove_seq

Overview:
- Sequencer for the vector move datapath (6-stage move pipe, no backpressure).
- Accepts one move command (source beat address, destination beat address, byte count, scalar flag, SEW) and performs these steps:
  - Reads source beats from the vector register file read port.
  - Forwards each beat with its destination address and tail byte-enables into the move pipe.
  - Counts returning results and pulses done when the last one lands.
- Sits between the vector issue stage and the move unit; owns one VRF read port.

Parameters:
REQ_DATA_WIDTH, 64, beat width in bits
REQ_ADDR_WIDTH, 32, VRF beat-address width
REQ_BE_DATA_WIDTH, REQ_DATA_WIDTH/8, bytes per beat
NBYTES_WIDTH, 16, command byte-count width
OUTST_WIDTH, 4, outstanding-beat counter width (must cover move latency + 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command
cmd_src_addr  in  REQ_ADDR_WIDTH  first source beat address
cmd_dst_addr  in  REQ_ADDR_WIDTH  first destination beat address
cmd_nbytes  in  NBYTES_WIDTH  bytes to move (vector form)
cmd_sca  in  1  scalar move: exactly one beat
cmd_sew  in  2  element width for scalar form: 0=8b, 1=16b, 2=32b, 3=64b
cmd_w_reg  in  1  result targets register file
stall  in  1  hold off new source reads
rd_en  out  1  VRF read request
rd_addr  out  REQ_ADDR_WIDTH  VRF read address
rd_data  in  REQ_DATA_WIDTH  VRF data, valid the cycle after rd_en
mv_valid  out  1  beat into move pipe
mv_addr  out  REQ_ADDR_WIDTH  destination beat address
mv_vec  out  REQ_DATA_WIDTH  beat data
mv_be  out  REQ_BE_DATA_WIDTH  byte enables
mv_w_reg  out  1  write-register flag
mv_sca  out  1  scalar flag
mv_out_valid  in  1  move pipe result valid (return)
busy  out  1  command in progress
done  out  1  one-cycle pulse, command complete

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready=1.
  - All other outputs 0.
  - State IDLE.
  - Counters 0.
- Beat count:
  - Vector form: beats = ceil(cmd_nbytes/REQ_BE_DATA_WIDTH).
  - Scalar form: beats = 1, regardless of nbytes.
- Byte enables:
  - Non-last beats: all ones.
  - Last vector beat: low (nbytes mod REQ_BE_DATA_WIDTH) bits set, or all ones if the remainder is 0.
  - Scalar beat: low 2^sew bits set.
- States:
  - IDLE:
    - cmd_ready=1. Accept on cmd_valid&cmd_ready; latch fields; cmd_ready->0, busy->1.
    - Vector with nbytes=0: go DONE.
    - Otherwise: go ISSUE.
  - ISSUE:
    - Each cycle with stall=0: rd_en=1, rd_addr=src+k, k increments.
    - With stall=1: rd_en=0, k holds.
    - After issuing the last beat: go DRAIN.
  - DRAIN:
    - No new reads.
    - Wait until no read is in flight and outstanding==0, then go DONE.
  - DONE:
    - done=1 for exactly one cycle; busy->0, cmd_ready->1; go IDLE.
    - Next command acceptable the cycle after done.
- Forwarding:
  - The cycle after rd_en=1: mv_valid=1, mv_vec=rd_data, mv_addr=dst+k', mv_be per beat, mv_w_reg/mv_sca from the latched command.
  - stall never cancels a read already issued.
- Outstanding counter:
  - Increments on mv_valid; decrements on mv_out_valid.
  - Both in the same cycle: no change.
  - Saturates at 0: a stray mv_out_valid after reset is ignored.
- Latency: command accepted at cycle T (unstalled):
  - rd_en for beat 0 at T+1.
  - mv_valid for beat 0 at T+2.
  - With the move pipe returning 6 cycles later, done for a 1-beat command at T+9.
- Address arithmetic is modulo 2^REQ_ADDR_WIDTH (wraps silently).
- Reset asserted mid-command: state returns to IDLE immediately, all outputs take reset values, and no done is produced.

Optional Feature:
- Macro VMOVE_SEQ_PERF_EN.
- Defined:
  - Adds output stall_cycles [31:0]: counts cycles in ISSUE with stall=1.
  - Cleared on command accept; holds value after done until the next accept.
  - Saturates at all ones; reset value 0.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Vector, nbytes=20, src=0x10, dst=0x40, no stall -> rd_addr 0x10,0x11,0x12 on consecutive cycles; mv_addr 0x40..0x42; mv_be FF,FF,0F; one done pulse after the third return.
- Scalar, sew=1, nbytes=100 -> exactly one beat; mv_be=0x03; mv_sca=1; done at T+9.
- Vector, nbytes=0 -> no rd_en, no mv_valid; done pulses 2 cycles after accept; cmd_ready back to 1.
- nbytes=32 with stall high for 3 cycles after beat 1 -> beat 2 read delayed 3 cycles; beat already in flight still forwarded; be all FF; done only when outstanding=0. With VMOVE_SEQ_PERF_EN, stall_cycles=3.
- src=0xFFFFFFFF, nbytes=16 -> rd_addr 0xFFFFFFFF then 0x00000000.
- rst pulled low during DRAIN with 2 beats outstanding -> busy=0, no done; returning mv_out_valid ignored; next command completes normally.

Source files
------------

// File: rtl/vmove_seq.sv
// vmove_seq: reads source beats from one VRF port, feeds them to the 6-stage move pipe, pulses done on the last return.
// Latency: accept at T -> rd_en T+1 -> mv_valid T+2 -> done one cycle after the final mv_out_valid.
// Backpressure: stall only holds off new reads (in-flight beats always forward); optional VMOVE_SEQ_PERF_EN adds stall_cycles.
module vmove_seq #(
   parameter int REQ_DATA_WIDTH    = 64,
   parameter int REQ_ADDR_WIDTH    = 32,
   parameter int REQ_BE_DATA_WIDTH = REQ_DATA_WIDTH / 8,
   parameter int NBYTES_WIDTH      = 16,
   parameter int OUTST_WIDTH       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [REQ_ADDR_WIDTH-1:0]    cmd_src_addr,
   input  logic [REQ_ADDR_WIDTH-1:0]    cmd_dst_addr,
   input  logic [NBYTES_WIDTH-1:0]      cmd_nbytes,
   input  logic                         cmd_sca,
   input  logic [1:0]                   cmd_sew,
   input  logic                         cmd_w_reg,
   input  logic                         stall,
   output logic                         rd_en,
   output logic [REQ_ADDR_WIDTH-1:0]    rd_addr,
   input  logic [REQ_DATA_WIDTH-1:0]    rd_data,
   output logic                         mv_valid,
   output logic [REQ_ADDR_WIDTH-1:0]    mv_addr,
   output logic [REQ_DATA_WIDTH-1:0]    mv_vec,
   output logic [REQ_BE_DATA_WIDTH-1:0] mv_be,
   output logic                         mv_w_reg,
   output logic                         mv_sca,
   input  logic                         mv_out_valid,
   output logic                         busy,
   output logic                         done
`ifdef VMOVE_SEQ_PERF_EN
   ,
   output logic [31:0]                  stall_cycles
`endif
);

   localparam int BE_LOG = $clog2(REQ_BE_DATA_WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                         state_q;
   logic [NBYTES_WIDTH-1:0]        k_q;
   logic [NBYTES_WIDTH-1:0]        beats_q;
   logic [REQ_BE_DATA_WIDTH-1:0]   last_be_q;
   logic [REQ_ADDR_WIDTH-1:0]      src_q;
   logic [REQ_ADDR_WIDTH-1:0]      dst_q;
   logic                           w_reg_q;
   logic                           sca_q;
   logic                           rd_en_q;
   logic [REQ_ADDR_WIDTH-1:0]      rd_addr_q;
   logic [REQ_ADDR_WIDTH-1:0]      rd_dst_q;
   logic [REQ_BE_DATA_WIDTH-1:0]   rd_be_q;
   logic                           mv_valid_q;
   logic [REQ_ADDR_WIDTH-1:0]      mv_addr_q;
   logic [REQ_BE_DATA_WIDTH-1:0]   mv_be_q;
   logic                           mv_w_reg_q;
   logic                           mv_sca_q;
   logic [OUTST_WIDTH-1:0]         outst_q;
   logic [OUTST_WIDTH-1:0]         outst_d;
   logic                           busy_q;
   logic                           done_q;
   logic                           cmd_ready_q;
`ifdef VMOVE_SEQ_PERF_EN
   logic [31:0]                    stall_cnt_q;
`endif

   logic                           accept;
   logic [BE_LOG-1:0]              cmd_rem;
   logic [NBYTES_WIDTH-1:0]        cmd_beats;
   logic [REQ_BE_DATA_WIDTH-1:0]   cmd_last_be;
   logic                           issue_go;
   logic                           issue_last;
   logic [NBYTES_WIDTH-1:0]        issue_k;
   logic [NBYTES_WIDTH-1:0]        issue_beats;
   logic [REQ_ADDR_WIDTH-1:0]      issue_src;
   logic [REQ_ADDR_WIDTH-1:0]      issue_dst;
   logic [REQ_BE_DATA_WIDTH-1:0]   issue_lbe;
   logic [REQ_BE_DATA_WIDTH-1:0]   issue_be;

   // Decode the offered command: beat count and the byte-enable of its final beat.
   always_comb begin
      cmd_rem     = cmd_nbytes[BE_LOG-1:0];
      cmd_beats   = (cmd_nbytes >> BE_LOG) + NBYTES_WIDTH'(cmd_rem != '0);
      cmd_last_be = '1;
      for (int b = 0; b < REQ_BE_DATA_WIDTH; b++) begin
         if (cmd_sca) begin
            cmd_last_be[b] = (b < (1 << cmd_sew));
         end else if (cmd_rem != '0) begin
            cmd_last_be[b] = (b < int'(cmd_rem));
         end
      end
      if (cmd_sca) begin
         cmd_beats = NBYTES_WIDTH'(1);
      end
   end

   // Beat 0 is issued on the accept edge itself so rd_en lands at T+1.
   always_comb begin
      accept      = cmd_valid && cmd_ready_q && (state_q == S_IDLE);
      issue_go    = 1'b0;
      issue_k     = k_q;
      issue_beats = beats_q;
      issue_src   = src_q;
      issue_dst   = dst_q;
      issue_lbe   = last_be_q;
      if (state_q == S_IDLE) begin
         issue_k     = '0;
         issue_beats = cmd_beats;
         issue_src   = cmd_src_addr;
         issue_dst   = cmd_dst_addr;
         issue_lbe   = cmd_last_be;
         issue_go    = accept && !stall && (cmd_beats != '0);
      end else if (state_q == S_ISSUE) begin
         issue_go    = !stall;
      end
      issue_last = (issue_k == issue_beats - NBYTES_WIDTH'(1));
      issue_be   = issue_last ? issue_lbe : '1;
   end

   always_comb begin
      outst_d = outst_q;
      if (mv_valid_q && !mv_out_valid) begin
         outst_d = outst_q + OUTST_WIDTH'(1);
      end else if (!mv_valid_q && mv_out_valid && (outst_q != '0)) begin
         outst_d = outst_q - OUTST_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         beats_q     <= '0;
         last_be_q   <= '0;
         src_q       <= '0;
         dst_q       <= '0;
         w_reg_q     <= 1'b0;
         sca_q       <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rd_dst_q    <= '0;
         rd_be_q     <= '0;
         mv_valid_q  <= 1'b0;
         mv_addr_q   <= '0;
         mv_be_q     <= '0;
         mv_w_reg_q  <= 1'b0;
         mv_sca_q    <= 1'b0;
         outst_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cmd_ready_q <= 1'b1;
`ifdef VMOVE_SEQ_PERF_EN
         stall_cnt_q <= '0;
`endif
      end else begin
         outst_q    <= outst_d;
         rd_en_q    <= issue_go;
         mv_valid_q <= rd_en_q;
         if (rd_en_q) begin
            mv_addr_q  <= rd_dst_q;
            mv_be_q    <= rd_be_q;
            mv_w_reg_q <= w_reg_q;
            mv_sca_q   <= sca_q;
         end

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  src_q       <= cmd_src_addr;
                  dst_q       <= cmd_dst_addr;
                  beats_q     <= cmd_beats;
                  last_be_q   <= cmd_last_be;
                  w_reg_q     <= cmd_w_reg;
                  sca_q       <= cmd_sca;
                  k_q         <= '0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
`ifdef VMOVE_SEQ_PERF_EN
                  stall_cnt_q <= '0;
`endif
                  if (cmd_beats == '0) begin
                     state_q <= S_DONE;
                  end else if (issue_go && issue_last) begin
                     state_q <= S_DRAIN;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
`ifdef VMOVE_SEQ_PERF_EN
               if (stall && (stall_cnt_q != '1)) begin
                  stall_cnt_q <= stall_cnt_q + 32'd1;
               end
`endif
               if (issue_go && issue_last) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               // outst_d lets done fire in the cycle right after the last return.
               if (!rd_en_q && !mv_valid_q && (outst_d == '0)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               // Zero-length commands arrive with done_q low and spend one extra cycle here.
               if (!done_q) begin
                  done_q <= 1'b1;
               end else begin
                  done_q      <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (issue_go) begin
            k_q       <= issue_k + NBYTES_WIDTH'(1);
            rd_addr_q <= issue_src + REQ_ADDR_WIDTH'(issue_k);
            rd_dst_q  <= issue_dst + REQ_ADDR_WIDTH'(issue_k);
            rd_be_q   <= issue_be;
         end
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign mv_valid  = mv_valid_q;
   assign mv_addr   = mv_addr_q;
   // VRF read data is already a register output and is valid in the mv_valid cycle.
   assign mv_vec    = rd_data;
   assign mv_be     = mv_be_q;
   assign mv_w_reg  = mv_w_reg_q;
   assign mv_sca    = mv_sca_q;
`ifdef VMOVE_SEQ_PERF_EN
   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vmove_seq.sv
// Bench for vmove_seq: VRF and 6-cycle move-pipe models, scoreboard of expected reads/beats, per-scenario tasks.
module tb_vmove_seq;
   localparam int DW = 64;
   localparam int AW = 32;
   localparam int BW = 8;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [AW-1:0] cmd_src_addr;
   logic [AW-1:0] cmd_dst_addr;
   logic [NW-1:0] cmd_nbytes;
   logic          cmd_sca;
   logic [1:0]    cmd_sew;
   logic          cmd_w_reg;
   logic          stall;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          mv_valid;
   logic [AW-1:0] mv_addr;
   logic [DW-1:0] mv_vec;
   logic [BW-1:0] mv_be;
   logic          mv_w_reg;
   logic          mv_sca;
   logic          mv_out_valid;
   logic          busy;
   logic          done;
`ifdef VMOVE_SEQ_PERF_EN
   logic [31:0]   stall_cycles;
`endif

   vmove_seq dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
      .cmd_nbytes(cmd_nbytes), .cmd_sca(cmd_sca), .cmd_sew(cmd_sew), .cmd_w_reg(cmd_w_reg),
      .stall(stall), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .mv_valid(mv_valid), .mv_addr(mv_addr), .mv_vec(mv_vec), .mv_be(mv_be),
      .mv_w_reg(mv_w_reg), .mv_sca(mv_sca), .mv_out_valid(mv_out_valid),
      .busy(busy), .done(done)
`ifdef VMOVE_SEQ_PERF_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [AW-1:0] addr; int cyc; } rd_exp_t;
   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] vec; logic [BW-1:0] be; logic w; logic sca; int cyc; } mv_exp_t;
   rd_exp_t rd_q[$];
   mv_exp_t mv_q[$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;

   function automatic logic [DW-1:0] vrf(input logic [AW-1:0] a);
      return {a ^ 32'hA5A5_5A5A, ~a};
   endfunction

   // Synchronous VRF: data for a read requested in cycle X is present in cycle X+1.
   logic          vrf_pend;
   logic [AW-1:0] vrf_pend_addr;
   always @(posedge clk) begin
      vrf_pend      = rd_en;
      vrf_pend_addr = rd_addr;
      #1;
      rd_data = vrf_pend ? vrf(vrf_pend_addr) : '0;
   end

   // Move pipe: every mv_valid returns as mv_out_valid six cycles later.
   logic [5:0] pipe_sr = '0;
   logic       stray_req = 1'b0;
   always @(posedge clk) begin
      pipe_sr = {pipe_sr[4:0], mv_valid};
      #1;
      mv_out_valid = pipe_sr[5] | stray_req;
      stray_req    = 1'b0;
   end

   always @(negedge clk) begin
      rd_exp_t re;
      mv_exp_t me;
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (rd_en) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_extra: rd_addr=%h at cycle %0d, required no read", rd_addr, cyc);
         end else begin
            re = rd_q.pop_front();
            if (rd_addr !== re.addr || cyc != re.cyc) begin
               errors++;
               $display("FAIL rd_beat: addr=%h cycle=%0d, required addr=%h cycle=%0d", rd_addr, cyc, re.addr, re.cyc);
            end
         end
      end
      if (mv_valid) begin
         checks++;
         if (mv_q.size() == 0) begin
            errors++;
            $display("FAIL mv_extra: mv_addr=%h at cycle %0d, required no beat", mv_addr, cyc);
         end else begin
            me = mv_q.pop_front();
            if (mv_addr !== me.addr || mv_vec !== me.vec || mv_be !== me.be ||
                mv_w_reg !== me.w || mv_sca !== me.sca || cyc != me.cyc) begin
               errors++;
               $display("FAIL mv_beat: addr=%h vec=%h be=%h w=%b sca=%b cyc=%0d, required addr=%h vec=%h be=%h w=%b sca=%b cyc=%0d",
                        mv_addr, mv_vec, mv_be, mv_w_reg, mv_sca, cyc, me.addr, me.vec, me.be, me.w, me.sca, me.cyc);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Offers one command and queues every read/beat it should produce; beats from stall_at on slip by stall_len.
   task automatic send_cmd(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [NW-1:0] nb,
                           input logic sca, input logic [1:0] sew, input logic w,
                           input int stall_at, input int stall_len, output int t);
      int beats;
      int rc;
      logic [BW-1:0] be;
      t = cyc;
      cmd_src_addr = src; cmd_dst_addr = dst; cmd_nbytes = nb;
      cmd_sca = sca; cmd_sew = sew; cmd_w_reg = w; cmd_valid = 1'b1;
      beats = sca ? 1 : (int'(nb) + BW - 1) / BW;
      for (int k = 0; k < beats; k++) begin
         rc = t + 1 + k + ((k >= stall_at) ? stall_len : 0);
         if (k != beats - 1)      be = 8'hFF;
         else if (sca)            be = 8'((1 << (1 << sew)) - 1);
         else if (nb % BW == 0)   be = 8'hFF;
         else                     be = 8'((1 << (nb % BW)) - 1);
         rd_q.push_back('{src + 32'(k), rc});
         mv_q.push_back('{dst + 32'(k), vrf(src + 32'(k)), be, w, sca, rc + 1});
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      int start;
      start = done_cnt;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step();
         if (done_cnt != start) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({cmd_ready, busy, done, rd_en, mv_valid} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: ready/busy/done/rd_en/mv_valid=%b, required 10000", {cmd_ready, busy, done, rd_en, mv_valid});
      end
      checks++;
      if (rd_addr !== '0 || mv_addr !== '0 || mv_be !== '0 || mv_w_reg !== 1'b0 || mv_sca !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: rd_addr=%h mv_addr=%h mv_be=%h w=%b sca=%b, required all 0", rd_addr, mv_addr, mv_be, mv_w_reg, mv_sca);
      end
`ifdef VMOVE_SEQ_PERF_EN
      checks++;
      if (stall_cycles !== 32'd0) begin
         errors++;
         $display("FAIL reset_perf: stall_cycles=%0d, required 0", stall_cycles);
      end
`endif
   endtask

   task automatic test_vector();
      int t; bit ok;
      send_cmd(32'h10, 32'h40, 16'd20, 1'b0, 2'd0, 1'b1, 99, 0, t);
      checks++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL vec_busy: busy=%b ready=%b, required busy=1 ready=0", busy, cmd_ready);
      end
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 11) begin
         errors++;
         $display("FAIL vec_done: seen=%b at T+%0d, required done at T+11", ok, last_done_cyc - t);
      end
      checks++;
      if ({cmd_ready, busy} !== 2'b01) begin
         errors++;
         $display("FAIL vec_done_cycle: ready/busy=%b, required 01 during done", {cmd_ready, busy});
      end
      step();
      checks++;
      if ({cmd_ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL vec_after: ready/busy/done=%b, required 100", {cmd_ready, busy, done});
      end
   endtask

   task automatic test_scalar();
      int t; bit ok;
      stray_req = 1'b1;
      repeat (3) step();
      send_cmd(32'h200, 32'h300, 16'd100, 1'b1, 2'd1, 1'b0, 99, 0, t);
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 9) begin
         errors++;
         $display("FAIL sca_done: seen=%b at T+%0d, required done at T+9", ok, last_done_cyc - t);
      end
      step();
      checks++;
      if (rd_q.size() != 0 || mv_q.size() != 0) begin
         errors++;
         $display("FAIL sca_leftover: %0d reads %0d beats pending, required 0 0", rd_q.size(), mv_q.size());
      end
   endtask

   task automatic test_zero();
      int t; bit ok;
      send_cmd(32'h55, 32'h66, 16'd0, 1'b0, 2'd0, 1'b0, 99, 0, t);
      wait_done(20, ok);
      checks++;
      if (!ok || last_done_cyc - t != 2) begin
         errors++;
         $display("FAIL zero_done: seen=%b at T+%0d, required done at T+2", ok, last_done_cyc - t);
      end
      step();
      checks++;
      if ({cmd_ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL zero_after: ready/busy/done=%b, required 100", {cmd_ready, busy, done});
      end
   endtask

   task automatic test_stall();
      int t; bit ok;
      send_cmd(32'h1000, 32'h2000, 16'd32, 1'b0, 2'd0, 1'b0, 2, 3, t);
      step();
      stall = 1'b1;
      repeat (3) step();
      stall = 1'b0;
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 15) begin
         errors++;
         $display("FAIL stall_done: seen=%b at T+%0d, required done at T+15", ok, last_done_cyc - t);
      end
      step();
`ifdef VMOVE_SEQ_PERF_EN
      checks++;
      if (stall_cycles !== 32'd3) begin
         errors++;
         $display("FAIL stall_perf: stall_cycles=%0d, required 3", stall_cycles);
      end
`endif
      checks++;
      if (rd_q.size() != 0 || mv_q.size() != 0) begin
         errors++;
         $display("FAIL stall_leftover: %0d reads %0d beats pending, required 0 0", rd_q.size(), mv_q.size());
      end
   endtask

   task automatic test_wrap();
      int t; bit ok;
      send_cmd(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd16, 1'b0, 2'd0, 1'b1, 99, 0, t);
`ifdef VMOVE_SEQ_PERF_EN
      checks++;
      if (stall_cycles !== 32'd0) begin
         errors++;
         $display("FAIL wrap_perf_clear: stall_cycles=%0d, required 0", stall_cycles);
      end
`endif
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 10) begin
         errors++;
         $display("FAIL wrap_done: seen=%b at T+%0d, required done at T+10", ok, last_done_cyc - t);
      end
      step();
   endtask

   task automatic test_reset_drain();
      int t; int snap; bit ok;
      send_cmd(32'h80, 32'h90, 16'd16, 1'b0, 2'd0, 1'b0, 99, 0, t);
      repeat (4) step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstd_busy: busy=%b before reset, required 1", busy);
      end
      snap = done_cnt;
      rst = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, busy, done, rd_en, mv_valid} !== 5'b10000) begin
         errors++;
         $display("FAIL rstd_outputs: ready/busy/done/rd_en/mv_valid=%b, required 10000", {cmd_ready, busy, done, rd_en, mv_valid});
      end
      repeat (2) step();
      rst = 1'b1;
      repeat (12) step();
      checks++;
      if (done_cnt != snap) begin
         errors++;
         $display("FAIL rstd_no_done: %0d done pulses after reset, required 0", done_cnt - snap);
      end
      send_cmd(32'hA0, 32'hB0, 16'd3, 1'b0, 2'd0, 1'b1, 99, 0, t);
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 9) begin
         errors++;
         $display("FAIL rstd_next: seen=%b at T+%0d, required done at T+9", ok, last_done_cyc - t);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int t; bit ok;
      send_cmd(32'h400, 32'h500, 16'd1, 1'b1, 2'd3, 1'b1, 99, 0, t);
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 9) begin
         errors++;
         $display("FAIL b2b_first: seen=%b at T+%0d, required done at T+9", ok, last_done_cyc - t);
      end
      step();
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ready: cmd_ready=%b the cycle after done, required 1", cmd_ready);
      end
      send_cmd(32'h600, 32'h700, 16'd8, 1'b0, 2'd0, 1'b0, 99, 0, t);
      wait_done(40, ok);
      checks++;
      if (!ok || last_done_cyc - t != 9) begin
         errors++;
         $display("FAIL b2b_second: seen=%b at T+%0d, required done at T+9", ok, last_done_cyc - t);
      end
      step();
      checks++;
      if (rd_q.size() != 0 || mv_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_leftover: %0d reads %0d beats pending, required 0 0", rd_q.size(), mv_q.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_nbytes = '0;
      cmd_sca = 1'b0; cmd_sew = 2'd0; cmd_w_reg = 1'b0; stall = 1'b0;
      repeat (3) step();
      test_reset();
      rst = 1'b1;
      step();
      test_vector();
      test_scalar();
      test_zero();
      test_stall();
      test_wrap();
      test_reset_drain();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
